// File: rtl/zaf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zaf_pkg
//  Description : Shared immediate-extension mode codes and helpers for the
//                ZAFx32 decode/execute boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
package zaf_pkg;

    // 3-bit extension mode carried alongside each immediate
    typedef logic [2:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO      = 3'd0;
    localparam ext_mode_t EXT_SIGN      = 3'd1;
    localparam ext_mode_t EXT_UPPER     = 3'd2;
    localparam ext_mode_t EXT_SIGN_SHL2 = 3'd3;
    localparam ext_mode_t EXT_BYTE_SIGN = 3'd4;
    localparam ext_mode_t EXT_BYTE_ZERO = 3'd5;

    // Codes 6 and 7 are reserved; they yield zero data with the error flag set
    function automatic logic ext_reserved(input ext_mode_t mode);
        return (mode > EXT_BYTE_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : ext_fifo2
//  Description : Two-entry synchronous FIFO. The head entry is always held in
//                r_mem0 so the output is a plain register with no muxing.
//  Revision    : 1.0 - initial release
// ============================================================================
module ext_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [0:W-1] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [0:W-1] o_head
);

    logic [0:W-1] r_mem0;   // head entry
    logic [0:W-1] r_mem1;   // second entry, valid only when count == 2
    logic [1:0]   r_count;

    logic w_push;
    logic w_pop;

    // Qualify requests with occupancy so a stray push/pop can never corrupt state
    always_comb begin
        w_push = i_push && (r_count != 2'd2);
        w_pop  = i_pop  && (r_count != 2'd0);
    end

    // Storage and occupancy update; reset clears everything, including the head
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_mem0 <= r_mem1;
                end else if (w_push) begin
                    // count == 1 with simultaneous push: new item becomes head
                    r_mem0 <= i_data;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_mem0 <= i_data;
                end else begin
                    r_mem1 <= i_data;
                end
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_head  = r_mem0;

endmodule
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_pipe
//  Description : Pipelined immediate extender. Decodes the mode, builds the
//                extended operand combinationally on accept and queues the
//                result (plus error flag) in a 2-entry FIFO with valid/ready
//                handshakes on both sides. Datapath vectors are MSB-at-0.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
    import zaf_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:IN_W-1]  in_imm,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:OUT_W-1] out_data,
    output logic             out_err
);

    localparam int c_pad  = OUT_W - IN_W;   // bits added in front of / behind the immediate
    localparam int c_bpad = OUT_W - 8;      // bits added in front of the low byte
    localparam int c_bsb  = IN_W - 8;       // index of the low byte's MSB

    logic [0:OUT_W-1] w_zext;
    logic [0:OUT_W-1] w_sext;
    logic [0:OUT_W-1] w_upper;
    logic [0:OUT_W-1] w_shl2;
    logic [0:OUT_W-1] w_bsext;
    logic [0:OUT_W-1] w_bzext;
    logic [0:OUT_W-1] w_ext;
    logic             w_err;
    logic             w_full;
    logic             w_empty;
    logic [0:OUT_W]   w_head;

    // Per-bit construction of every candidate result; all index arithmetic is
    // resolved at elaboration so no out-of-range selects exist for any legal
    // parameter pair.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
        if (gi < c_pad) begin : g_pad_hi
            assign w_zext[gi] = 1'b0;
            assign w_sext[gi] = in_imm[0];
        end else begin : g_imm_lo
            assign w_zext[gi] = in_imm[gi - c_pad];
            assign w_sext[gi] = in_imm[gi - c_pad];
        end

        if (gi < IN_W) begin : g_up_hi
            assign w_upper[gi] = in_imm[gi];
        end else begin : g_up_lo
            assign w_upper[gi] = 1'b0;
        end

        if (gi + 2 < OUT_W) begin : g_shl_keep
            assign w_shl2[gi] = w_sext[gi + 2];
        end else begin : g_shl_zero
            assign w_shl2[gi] = 1'b0;
        end

        if (gi < c_bpad) begin : g_byte_hi
            assign w_bsext[gi] = in_imm[c_bsb];
            assign w_bzext[gi] = 1'b0;
        end else begin : g_byte_lo
            assign w_bsext[gi] = in_imm[c_bsb + gi - c_bpad];
            assign w_bzext[gi] = in_imm[c_bsb + gi - c_bpad];
        end
    end

    // Mode select; reserved codes produce zero data and raise the error flag
    always_comb begin
        w_ext = '0;
        w_err = ext_reserved(in_mode);
        case (in_mode)
            EXT_ZERO:      w_ext = w_zext;
            EXT_SIGN:      w_ext = w_sext;
            EXT_UPPER:     w_ext = w_upper;
            EXT_SIGN_SHL2: w_ext = w_shl2;
            EXT_BYTE_SIGN: w_ext = w_bsext;
            EXT_BYTE_ZERO: w_ext = w_bzext;
            default:       w_ext = '0;
        endcase
    end

    ext_fifo2 #(
        .W (OUT_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  ({w_ext, w_err}),
        .i_pop   (out_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_head[0:OUT_W-1];
    assign out_err   = w_head[OUT_W];

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_ext_pipe
//  Description : Self-checking bench for imm_ext_pipe (default parameters).
//                A queue-based reference model tracks expected queue contents;
//                directed tasks pin literal results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    logic [32:0] q[$];   // expected entries: {err, data}

    always #5 clk = ~clk;

    imm_ext_pipe #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    // Reference extension straight from the mode definitions
    function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [2:0] mode);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (mode)
            3'd0:    return {1'b0, 16'h0000, imm};
            3'd1:    return {1'b0, s};
            3'd2:    return {1'b0, imm, 16'h0000};
            3'd3:    return {1'b0, s << 2};
            3'd4:    return {1'b0, {24{imm[7]}}, imm[7:0]};
            3'd5:    return {1'b0, 24'h000000, imm[7:0]};
            default: return {1'b1, 32'h00000000};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("in_ready_model", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
            chk("out_valid_model", {63'd0, out_valid}, {63'd0, (q.size() != 0)});
            if (out_valid && q.size() != 0) begin
                chk("out_data_model", {32'd0, out_data}, {32'd0, q[0][31:0]});
                chk("out_err_model", {63'd0, out_err}, {63'd0, q[0][32]});
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(ref_ext(in_imm, in_mode));
        end
    end

    // Present one item (called at posedge+1); returns at posedge+1 after accept
    task automatic send(input logic [15:0] imm, input logic [2:0] mode);
        int n;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready stuck low, imm 0x%0h", imm);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send to an empty queue and check the literal result one cycle later
    task automatic send_lit(input string name, input logic [15:0] imm, input logic [2:0] mode,
                            input logic [31:0] exp_data, input logic exp_err);
        send(imm, mode);
        @(negedge clk);
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_data"}, {32'd0, out_data}, {32'd0, exp_data});
        chk({name, "_err"}, {63'd0, out_err}, {63'd0, exp_err});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        @(posedge clk);
        #1;

        // Mode sweep
        send_lit("zero_8004",  16'h8004, 3'd0, 32'h00008004, 1'b0);
        send_lit("sign_8004",  16'h8004, 3'd1, 32'hFFFF8004, 1'b0);
        send_lit("upper_8004", 16'h8004, 3'd2, 32'h80040000, 1'b0);
        send_lit("shl2_8004",  16'h8004, 3'd3, 32'hFFFE0010, 1'b0);
        send_lit("shl2_7ffc",  16'h7FFC, 3'd3, 32'h0001FFF0, 1'b0);
        send_lit("bsign_1280", 16'h1280, 3'd4, 32'hFFFFFF80, 1'b0);
        send_lit("bzero_1280", 16'h1280, 3'd5, 32'h00000080, 1'b0);
        send_lit("rsv6_ffff",  16'hFFFF, 3'd6, 32'h00000000, 1'b1);
        send_lit("sign_0001",  16'h0001, 3'd1, 32'h00000001, 1'b0);
        send_lit("rsv7_1234",  16'h1234, 3'd7, 32'h00000000, 1'b1);

        // Backpressure: A, B absorbed, C held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 16'h00A1;
        in_mode   = 3'd0;
        @(posedge clk);
        #1;
        in_imm    = 16'h00B2;
        @(posedge clk);
        #1;
        in_imm    = 16'h00C3;
        @(negedge clk);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_head_a", {32'd0, out_data}, 64'h00A1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_still_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        // First pop happens at the next edge; C is accepted one edge later
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        chk("bp_head_b", {32'd0, out_data}, 64'h00B2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_head_c", {32'd0, out_data}, 64'h00C3);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Streaming: 100 back-to-back items
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'($urandom);
            in_mode  = 3'($urandom_range(0, 7));
            @(negedge clk);
            if (!in_ready) drops++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stream_no_drop", 64'(drops), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset with two entries queued
        out_ready = 1'b0;
        send(16'h1111, 3'd0);
        send(16'h2222, 3'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_data_clr", {32'd0, out_data}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_lit("post_rst_item", 16'h8001, 3'd1, 32'hFFFF8001, 1'b0);
        n = 0;
        while (n < 3) begin
            @(negedge clk);
            chk("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
            n++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
